mem_requester: RTL and testbench
================================

# mem_requester

Initiator-side bridge between a CPU/load-store unit and the byte-addressed, variable-latency `memory` block. Accepts one load or store request at a time and drives the memory's `start`/`rwn`/`ready` handshake. Handles byte, half and word sizes: sub-word stores use an internal read-modify-write, and sub-word loads are sign- or zero-extended. Adds a busy timeout and a single-cycle response pulse.

## Interface
- `TIMEOUT`, 16: maximum consecutive cycles spent in an ISSUE or WAIT state before abort; must be ≥ 8.
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; a request is accepted on the edge where `req_valid & req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `req_signed` in 1: sign-extend sub-word load data.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, low bytes used for sub-word stores.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: load result; 0 for stores and errors.
- `rsp_err` out 1: qualifies `rsp_valid`; set on timeout or reserved size.
- `mem_start` out 1: memory request strobe.
- `mem_rwn` out 1: 1 = read, 0 = write.
- `mem_address` out 32: registered copy of `req_addr`.
- `mem_data_in` out 32: registered write word.
- `mem_data_out` in 32: memory read data, valid when `mem_ready` returns high.
- `mem_ready` in 1: memory idle.

## Operation
- States:
  - IDLE
  - RD_ISSUE, RD_WAIT
  - WR_ISSUE, WR_WAIT
  - RESP
- On accept, the request fields are captured into registers. `mem_address` is loaded with `req_addr`.
- Routing from IDLE:
  - Reserved size → RESP with `rsp_err=1` (no memory access).
  - Load → RD_ISSUE.
  - Word store → WR_ISSUE with `mem_data_in = req_wdata`.
  - Byte or half store → RD_ISSUE.
- ISSUE states:
  - `mem_start` is high combinationally iff in an ISSUE state and `mem_ready=1`.
  - On that edge, move to the matching WAIT state.
  - `mem_rwn` is 1 in RD_* and 0 in WR_*.
- WAIT states:
  - On the first edge with `mem_ready=1`, the transaction completes.
  - The first WAIT cycle always sees `mem_ready=0`, because the memory drops ready the edge after it samples start.
- RD_WAIT completion:
  - Load: `rsp_rdata` = extracted data; go to RESP.
  - Sub-word store: merge and go to WR_ISSUE.
    - Byte: `mem_data_in = {rd[31:8], wdata[7:0]}`.
    - Half: `mem_data_in = {rd[31:16], wdata[15:0]}`.
- Load extraction, with `rd = mem_data_out` (byte at `addr` is `rd[7:0]`, little-endian):
  - Byte: `rd[7:0]`, extended with `rd[7]` if `req_signed`, else zeros.
  - Half: `rd[15:0]`, extended with `rd[15]` if `req_signed`, else zeros.
  - Word: `rd`.
- Timeout:
  - A counter clears on entry to each ISSUE or WAIT state and increments each cycle in that state.
  - When it reaches `TIMEOUT`, go to RESP with `rsp_err=1` and `rsp_rdata=0`.
  - No write phase follows an aborted RMW read.
- RESP: `rsp_valid=1` for exactly one cycle, then IDLE. `rsp_rdata` and `rsp_err` hold until the next accept.
- A new request can be accepted in the cycle after RESP.

## Timing
- Reset values:
  - State IDLE; `req_ready=1`.
  - `rsp_valid=0`, `rsp_err=0`, `rsp_rdata=0`.
  - `mem_start=0`, `mem_rwn=1`, `mem_address=0`, `mem_data_in=0`; counter 0.
- Reset mid-transaction aborts with no response and returns to IDLE. The memory shares the reset.
- Cycle 0 is the accept cycle, and `a = req_addr[1:0]`. The memory holds `ready` low for `a+1` cycles after sampling start.
- Single access (load or word store):
  - Cycle 1: ISSUE, `mem_start=1`.
  - Cycles 2..2+a: `mem_ready=0`.
  - Cycle 3+a: `mem_ready=1`, capture.
  - Cycle 4+a: `rsp_valid`.
- Sub-word store:
  - Read completes in cycle 3+a.
  - Cycle 4+a: WR_ISSUE.
  - Cycle 6+2a: write completes.
  - Cycle 7+2a: `rsp_valid`.
- Reserved size: `rsp_valid` in cycle 1.
- If `mem_ready=0` at ISSUE, `mem_start` stays low and the FSM waits, bounded by the timeout.
- `mem_address`, `mem_rwn` and `mem_data_in` are stable from ISSUE through the WAIT completion edge.
- Address arithmetic: addresses pass through unmodified. Wrap at 0xFFFF is the memory's, over 16 bits.

## Test plan
- Word store 0xDEADBEEF at 0x100, then word load at 0x100:
  - Store `rsp_valid` at cycle 4.
  - Load returns 0xDEADBEEF at cycle 4 with `rsp_err=0`.
- Byte store 0x55 (`wdata` 0x12345655) at 0x101 over 0xDEADBEEF:
  - Exactly one read then one write issued; `rsp_valid` at cycle 9.
  - Word load at 0x100 returns 0xDEAD55EF.
- After the byte store above:
  - Signed byte load at 0x103 → 0xFFFFFFDE at cycle 7.
  - Unsigned half load at 0x102 → 0x0000DEAD at cycle 6.
  - Signed half load at 0x100 → 0x000055EF.
- Reserved size 11 → `rsp_valid` and `rsp_err=1` at cycle 1, `mem_start` never asserted.
- Timeout: bench memory model holds `mem_ready=0` after start with `TIMEOUT=16` → `rsp_err=1`, `rsp_rdata=0`, no write issued for a sub-word store.
- Assert `reset` during the RD_WAIT of a sub-word store:
  - No `rsp_valid`; all outputs at reset values next cycle.
  - A following word load of 0x0 returns 0x00000000.

Source files
------------

// File: rtl/mem_requester.sv
// mem_requester: initiator-side bridge from a load/store unit to the
// byte-addressed, variable-latency memory block. One request at a time.
// Sub-word stores are done as read-modify-write; sub-word loads are
// sign- or zero-extended. Every ISSUE/WAIT state is bounded by TIMEOUT.
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_we, req_size, req_signed request kind: store, size, sign-extend
//   req_addr, req_wdata          byte address and store data
//   rsp_valid, rsp_rdata, rsp_err one-cycle completion pulse with result
//   mem_start, mem_rwn           memory strobe and direction (1 = read)
//   mem_address, mem_data_in     registered address and write word
//   mem_data_out, mem_ready      memory read data and idle flag
module mem_requester #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_start,
  output logic        mem_rwn,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  input  logic        mem_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT, RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic [1:0]    size_q;
  logic          signed_q;
  logic [15:0]   wdata_q;   // only the low half is ever merged
  logic [31:0]   load_data;
  logic [31:0]   merge_data;
  logic          expired;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign mem_start = ((state == RD_ISSUE) || (state == WR_ISSUE)) && mem_ready;
  assign expired   = (cnt == CNT_LAST);

  // Little-endian: the byte at the request address is mem_data_out[7:0].
  always_comb begin
    load_data  = mem_data_out;
    merge_data = mem_data_out;
    case (size_q)
      2'b00: begin
        load_data  = {{24{signed_q & mem_data_out[7]}}, mem_data_out[7:0]};
        merge_data = {mem_data_out[31:8], wdata_q[7:0]};
      end
      2'b01: begin
        load_data  = {{16{signed_q & mem_data_out[15]}}, mem_data_out[15:0]};
        merge_data = {mem_data_out[31:16], wdata_q};
      end
      default: begin
        load_data  = mem_data_out;
        merge_data = mem_data_out;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      wdata_q     <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      mem_rwn     <= 1'b1;
      mem_address <= '0;
      mem_data_in <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            size_q      <= req_size;
            signed_q    <= req_signed;
            wdata_q     <= req_wdata[15:0];
            mem_address <= req_addr;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            cnt         <= '0;
            if (req_size == 2'b11) begin
              rsp_err <= 1'b1;
              state   <= RESP;
            end else if (req_we && (req_size == 2'b10)) begin
              mem_rwn     <= 1'b0;
              mem_data_in <= req_wdata;
              state       <= WR_ISSUE;
            end else begin
              // loads and the read half of a sub-word store
              mem_rwn <= 1'b1;
              state   <= RD_ISSUE;
            end
          end
        end

        RD_ISSUE, WR_ISSUE: begin
          if (mem_ready) begin
            state <= (state == RD_ISSUE) ? RD_WAIT : WR_WAIT;
            cnt   <= '0;
          end else if (expired) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RD_WAIT: begin
          if (mem_ready) begin
            if (we_q) begin
              mem_data_in <= merge_data;
              mem_rwn     <= 1'b0;
              cnt         <= '0;
              state       <= WR_ISSUE;
            end else begin
              rsp_rdata <= load_data;
              state     <= RESP;
            end
          end else if (expired) begin
            // an aborted RMW read never proceeds to its write
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        WR_WAIT: begin
          if (mem_ready) begin
            state <= RESP;
          end else if (expired) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_requester.sv
// Testbench for mem_requester with a behavioural byte-addressed memory:
// ready drops the edge after start is sampled and stays low for
// addr[1:0]+1 cycles (or forever while hang is set); 16-bit address wrap.
module tb_mem_requester;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_start;
  logic        mem_rwn;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out = '0;
  logic        mem_ready = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  mem_requester #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_start(mem_start), .mem_rwn(mem_rwn),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  bit [7:0]   mem [0:65535];
  bit         hang = 1'b0;
  logic [1:0] mcnt = 2'd0;
  logic [15:0] b0, b1, b2, b3;

  assign b0 = mem_address[15:0];
  assign b1 = b0 + 16'd1;
  assign b2 = b0 + 16'd2;
  assign b3 = b0 + 16'd3;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_ready <= 1'b1;
      mcnt      <= 2'd0;
    end else if (mem_ready && mem_start) begin
      mem_ready <= 1'b0;
      mcnt      <= mem_address[1:0];
      if (mem_rwn) begin
        mem_data_out <= {mem[b3], mem[b2], mem[b1], mem[b0]};
      end else begin
        mem[b0] <= mem_data_in[7:0];
        mem[b1] <= mem_data_in[15:8];
        mem[b2] <= mem_data_in[23:16];
        mem[b3] <= mem_data_in[31:24];
      end
    end else if (!mem_ready && !hang) begin
      if (mcnt == 2'd0) mem_ready <= 1'b1;
      else              mcnt <= mcnt - 2'd1;
    end
  end

  // ---------------- transaction driver ----------------
  // Cycle 0 is the accept cycle; cyc is the cycle of rsp_valid (-1 if none).
  task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int cyc, output logic [31:0] rdata, output logic err,
                         output int n_rd, output int n_wr);
    cyc = -1; rdata = 'x; err = 1'bx; n_rd = 0; n_wr = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (mem_start) begin
        if (mem_rwn) n_rd++; else n_wr++;
      end
      if (rsp_valid) begin
        cyc = k; rdata = rsp_rdata; err = rsp_err;
        break;
      end
    end
    $display("txn we=%0b size=%0d sgn=%0b addr=%08h wdata=%08h -> cyc=%0d rdata=%08h err=%0b rd=%0d wr=%0d",
             we, size, sgn, addr, wdata, cyc, rdata, err, n_rd, n_wr);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    n_cmp++; if ({rsp_err, rsp_rdata} !== 33'd0) begin n_bad++; $display("FAIL reset_rsp got err=%b rdata=%08h want 0/0", rsp_err, rsp_rdata); end
    n_cmp++; if ({mem_start, mem_rwn} !== 2'b01) begin n_bad++; $display("FAIL reset_mem_ctl got start=%b rwn=%b want 0/1", mem_start, mem_rwn); end
    n_cmp++; if ({mem_address, mem_data_in} !== 64'd0) begin n_bad++; $display("FAIL reset_mem_bus got addr=%08h data=%08h want 0/0", mem_address, mem_data_in); end
    reset = 1'b0;
  endtask

  task automatic test_word();
    int cyc, nr, nw; logic [31:0] rd; logic er;
    run_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, cyc, rd, er, nr, nw);
    n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL wstore_cycle got=%0d want=4", cyc); end
    n_cmp++; if ({er, rd, nr, nw} !== {1'b0, 32'h0, 32'd0, 32'd1}) begin n_bad++; $display("FAIL wstore_result got err=%b rdata=%08h rd=%0d wr=%0d want 0/0/0/1", er, rd, nr, nw); end
    run_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, cyc, rd, er, nr, nw);
    n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL wload_cycle got=%0d want=4", cyc); end
    n_cmp++; if ({er, rd} !== {1'b0, 32'hDEADBEEF}) begin n_bad++; $display("FAIL wload_data got err=%b rdata=%08h want 0/deadbeef", er, rd); end
    @(posedge clk); #1;
    n_cmp++; if ({rsp_valid, rsp_rdata} !== {1'b0, 32'hDEADBEEF}) begin n_bad++; $display("FAIL rsp_hold got valid=%b rdata=%08h want 0/deadbeef", rsp_valid, rsp_rdata); end
  endtask

  task automatic test_byte_store();
    int cyc, nr, nw; logic [31:0] rd; logic er;
    run_req(1'b1, 2'b00, 1'b0, 32'h101, 32'h12345655, cyc, rd, er, nr, nw);
    n_cmp++; if (cyc !== 9) begin n_bad++; $display("FAIL bstore_cycle got=%0d want=9", cyc); end
    n_cmp++; if ({er, nr, nw} !== {1'b0, 32'd1, 32'd1}) begin n_bad++; $display("FAIL bstore_access got err=%b rd=%0d wr=%0d want 0/1/1", er, nr, nw); end
    run_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, cyc, rd, er, nr, nw);
    n_cmp++; if (rd !== 32'hDEAD55EF) begin n_bad++; $display("FAIL bstore_readback got=%08h want=dead55ef", rd); end
  endtask

  task automatic test_subword_load();
    int cyc, nr, nw; logic [31:0] rd; logic er;
    run_req(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, cyc, rd, er, nr, nw);
    n_cmp++; if ({cyc, rd} !== {32'd7, 32'hFFFFFFDE}) begin n_bad++; $display("FAIL sbyte_load got cyc=%0d rdata=%08h want 7/ffffffde", cyc, rd); end
    run_req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, cyc, rd, er, nr, nw);
    n_cmp++; if (rd !== 32'h000000DE) begin n_bad++; $display("FAIL ubyte_load got=%08h want=000000de", rd); end
    run_req(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, cyc, rd, er, nr, nw);
    n_cmp++; if ({cyc, rd} !== {32'd6, 32'h0000DEAD}) begin n_bad++; $display("FAIL uhalf_load got cyc=%0d rdata=%08h want 6/0000dead", cyc, rd); end
    run_req(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, cyc, rd, er, nr, nw);
    n_cmp++; if (rd !== 32'hFFFFDEAD) begin n_bad++; $display("FAIL shalf_neg_load got=%08h want=ffffdead", rd); end
    run_req(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, cyc, rd, er, nr, nw);
    n_cmp++; if ({cyc, er, rd} !== {32'd4, 1'b0, 32'h000055EF}) begin n_bad++; $display("FAIL shalf_pos_load got cyc=%0d err=%b rdata=%08h want 4/0/000055ef", cyc, er, rd); end
  endtask

  task automatic test_half_store();
    int cyc, nr, nw; logic [31:0] rd; logic er;
    run_req(1'b1, 2'b01, 1'b0, 32'h102, 32'hAAAA1234, cyc, rd, er, nr, nw);
    n_cmp++; if ({cyc, nr, nw} !== {32'd11, 32'd1, 32'd1}) begin n_bad++; $display("FAIL hstore got cyc=%0d rd=%0d wr=%0d want 11/1/1", cyc, nr, nw); end
    run_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, cyc, rd, er, nr, nw);
    n_cmp++; if (rd !== 32'h123455EF) begin n_bad++; $display("FAIL hstore_readback got=%08h want=123455ef", rd); end
  endtask

  task automatic test_reserved();
    int cyc, nr, nw; logic [31:0] rd; logic er;
    run_req(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, cyc, rd, er, nr, nw);
    n_cmp++; if ({cyc, er, rd} !== {32'd1, 1'b1, 32'h0}) begin n_bad++; $display("FAIL reserved got cyc=%0d err=%b rdata=%08h want 1/1/0", cyc, er, rd); end
    n_cmp++; if (nr + nw !== 0) begin n_bad++; $display("FAIL reserved_no_access got starts=%0d want=0", nr + nw); end
  endtask

  task automatic test_timeout();
    int cyc, nr, nw; logic [31:0] rd; logic er;
    hang = 1'b1;
    run_req(1'b1, 2'b00, 1'b0, 32'h200, 32'h000000AB, cyc, rd, er, nr, nw);
    n_cmp++; if (cyc == -1) begin n_bad++; $display("FAIL timeout_no_rsp got=none want=rsp_valid within 60 cycles"); end
    n_cmp++; if ({er, rd} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL timeout_result got err=%b rdata=%08h want 1/0", er, rd); end
    n_cmp++; if ({nr, nw} !== {32'd1, 32'd0}) begin n_bad++; $display("FAIL timeout_access got rd=%0d wr=%0d want 1/0", nr, nw); end
    hang = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if (mem[16'h200] !== 8'h00) begin n_bad++; $display("FAIL timeout_mem_untouched got=%02h want=00", mem[16'h200]); end
  endtask

  task automatic test_reset_mid();
    int cyc, nr, nw; logic [31:0] rd; logic er; bit seen;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h1; req_wdata = 32'h77;
    @(posedge clk); #1;   // cycle 1: RD_ISSUE
    req_valid = 1'b0;
    @(posedge clk); #1;   // cycle 2: RD_WAIT
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({req_ready, rsp_valid, rsp_err, mem_start, mem_rwn} !== 5'b10001) begin n_bad++; $display("FAIL midreset_ctl got ready=%b valid=%b err=%b start=%b rwn=%b want 1/0/0/0/1", req_ready, rsp_valid, rsp_err, mem_start, mem_rwn); end
    n_cmp++; if ({rsp_rdata, mem_address, mem_data_in} !== 96'd0) begin n_bad++; $display("FAIL midreset_data got rdata=%08h addr=%08h data=%08h want 0/0/0", rsp_rdata, mem_address, mem_data_in); end
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (rsp_valid) seen = 1'b1; end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midreset_no_rsp got rsp_valid=1 want=0"); end
    run_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, cyc, rd, er, nr, nw);
    n_cmp++; if ({cyc, er, rd} !== {32'd4, 1'b0, 32'h0}) begin n_bad++; $display("FAIL midreset_load got cyc=%0d err=%b rdata=%08h want 4/0/0", cyc, er, rd); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_store();
    test_subword_load();
    test_half_store();
    test_reserved();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
